// File: rtl/lockstep_compare_if.sv
// Bundle of stream, control and status signals between the lockstep checker
// and the harness that feeds it. The harness side is the master; the checker
// is the slave.
interface lockstep_compare_if #(
  parameter int WIDTH = 237,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic                     ref_valid;
  logic [WIDTH-1:0]         ref_data;
  logic                     dut_valid;
  logic [WIDTH-1:0]         dut_data;
  logic [WIDTH-1:0]         mask;
  logic                     clear;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     mismatch;
  logic                     error;
  logic                     overflow;
  logic [CNT_W-1:0]         compare_count;
  logic [CNT_W-1:0]         mismatch_count;
  logic [CNT_W-1:0]         first_index;
  logic [WIDTH-1:0]         first_diff;
  logic [$clog2(DEPTH):0]   ref_level;
  logic [$clog2(DEPTH):0]   dut_level;

  modport master (
    output ref_valid, ref_data, dut_valid, dut_data, mask, clear,
    input  out_valid, out_data, mismatch, error, overflow,
           compare_count, mismatch_count, first_index, first_diff,
           ref_level, dut_level
  );

  modport slave (
    input  ref_valid, ref_data, dut_valid, dut_data, mask, clear,
    output out_valid, out_data, mismatch, error, overflow,
           compare_count, mismatch_count, first_index, first_diff,
           ref_level, dut_level
  );
endinterface

// File: rtl/lockstep_compare.sv
// Lockstep checker: aligns a reference stream and an implementation stream
// through one FIFO per side, compares the heads under a don't-care mask, and
// keeps counters plus a capture of the first divergence.
module lockstep_compare #(
  parameter int WIDTH = 237,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  lockstep_compare_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] dut_mem [DEPTH];
  logic [PTR_W-1:0] ref_wr, ref_rd, dut_wr, dut_rd;
  logic [LVL_W-1:0] ref_lvl, dut_lvl;

  logic             pop;
  logic             ref_push, dut_push, any_drop;
  logic [WIDTH-1:0] ref_head, diff;
  logic             diff_hit;

  logic [CNT_W-1:0] cnt_base, mcnt_base;
  logic             err_base, ovf_base;

  logic             out_valid_q, mismatch_q, error_q, overflow_q;
  logic [WIDTH-1:0] out_data_q, first_diff_q;
  logic [CNT_W-1:0] compare_count_q, mismatch_count_q, first_index_q;

  // A compare only uses entries already present at the start of the cycle;
  // a full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    pop      = (ref_lvl != '0) && (dut_lvl != '0);
    ref_push = bus.ref_valid && ((ref_lvl != LVL_W'(DEPTH)) || pop);
    dut_push = bus.dut_valid && ((dut_lvl != LVL_W'(DEPTH)) || pop);
    any_drop = (bus.ref_valid && !ref_push) || (bus.dut_valid && !dut_push);
    ref_head = ref_mem[ref_rd];
    diff     = (ref_head ^ dut_mem[dut_rd]) & ~bus.mask;
    diff_hit = pop && (diff != '0);
    cnt_base  = bus.clear ? '0 : compare_count_q;
    mcnt_base = bus.clear ? '0 : mismatch_count_q;
    err_base  = bus.clear ? 1'b0 : error_q;
    ovf_base  = bus.clear ? 1'b0 : overflow_q;
  end

  // FIFO storage carries no reset; validity is tracked by the levels alone.
  always_ff @(posedge clk) begin
    if (ref_push) ref_mem[ref_wr] <= bus.ref_data;
    if (dut_push) dut_mem[dut_wr] <= bus.dut_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_wr  <= '0;
      ref_rd  <= '0;
      dut_wr  <= '0;
      dut_rd  <= '0;
      ref_lvl <= '0;
      dut_lvl <= '0;
    end else begin
      if (ref_push) ref_wr <= ref_wr + 1'b1;
      if (dut_push) dut_wr <= dut_wr + 1'b1;
      if (pop) begin
        ref_rd <= ref_rd + 1'b1;
        dut_rd <= dut_rd + 1'b1;
      end
      ref_lvl <= ref_lvl + LVL_W'(ref_push) - LVL_W'(pop);
      dut_lvl <= dut_lvl + LVL_W'(dut_push) - LVL_W'(pop);
    end
  end

  // Compare results and status; clear is applied first so a same-cycle
  // compare lands on freshly zeroed counters and capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      mismatch_q       <= 1'b0;
      error_q          <= 1'b0;
      overflow_q       <= 1'b0;
      compare_count_q  <= '0;
      mismatch_count_q <= '0;
      first_index_q    <= '0;
      first_diff_q     <= '0;
    end else begin
      out_valid_q <= pop;
      mismatch_q  <= diff_hit;
      if (pop) out_data_q <= ref_head;
      compare_count_q  <= (pop && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
      mismatch_count_q <= (diff_hit && (mcnt_base != '1)) ? mcnt_base + CNT_W'(1) : mcnt_base;
      error_q    <= err_base || diff_hit;
      overflow_q <= ovf_base || any_drop;
      if (diff_hit && !err_base) begin
        first_index_q <= cnt_base;
        first_diff_q  <= diff;
      end else if (bus.clear) begin
        first_index_q <= '0;
        first_diff_q  <= '0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.error          = error_q;
  assign bus.overflow       = overflow_q;
  assign bus.compare_count  = compare_count_q;
  assign bus.mismatch_count = mismatch_count_q;
  assign bus.first_index    = first_index_q;
  assign bus.first_diff     = first_diff_q;
  assign bus.ref_level      = ref_lvl;
  assign bus.dut_level      = dut_lvl;
endmodule
